// File: rtl/brch_pkg.sv
// -----------------------------------------------------------------------------
// brch_pkg
// Shared definitions for the branch checkpoint controller:
//   NUM_LANES  - decode group width
//   ROB_W      - ROB index width
//   POS_W      - free-list pointer width
//   state_e    - recovery FSM states
//   slot_t     - one checkpoint slot {vld, rob_indx, pos}
// -----------------------------------------------------------------------------
package brch_pkg;

  localparam int NUM_LANES = 4;
  localparam int ROB_W     = 6;
  localparam int POS_W     = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_RECOVER = 2'd2
  } state_e;

  typedef struct packed {
    logic             vld;
    logic [ROB_W-1:0] rob_indx;
    logic [POS_W-1:0] pos;
  } slot_t;

endpackage

// File: rtl/brch_age_matrix.sv
// -----------------------------------------------------------------------------
// brch_age_matrix
// N x N relative-age matrix for the checkpoint slots. Bit yng[i][j] = 1 means
// slot i is younger than slot j.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset (matrix cleared)
//   vld          - currently valid slots
//   alloc_mask   - slots written this cycle (allocated in ascending slot
//                  order, so a lower allocated slot belongs to a lower lane)
//   free_mask    - slots invalidated this cycle (row and column cleared)
//   sel          - one-hot slot whose younger set is requested
//   younger      - slots younger than the selected slot
// -----------------------------------------------------------------------------
module brch_age_matrix #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] vld,
  input  logic [N-1:0] alloc_mask,
  input  logic [N-1:0] free_mask,
  input  logic [N-1:0] sel,
  output logic [N-1:0] younger
);

  logic [N-1:0] yng_q [N];
  logic [N-1:0] yng_d [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        yng_d[i][j] = yng_q[i][j];
        // A new slot is younger than every valid slot and every slot taken
        // by a lower lane in the same group.
        if (alloc_mask[i]) begin
          yng_d[i][j] = vld[j] | (alloc_mask[j] && (j < i));
        end else if (alloc_mask[j]) begin
          yng_d[i][j] = 1'b0;
        end
        // Freeing wins so a slot retired this cycle never looks older.
        if (free_mask[i] || free_mask[j]) begin
          yng_d[i][j] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        yng_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        yng_q[i] <= yng_d[i];
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_younger
    assign younger[gi] = |(yng_q[gi] & sel);
  end

endmodule

// File: rtl/brch_ckpt_ctrl.sv
// -----------------------------------------------------------------------------
// brch_ckpt_ctrl
// Branch checkpoint allocator with mispredict flush/recovery sequencing.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   brch_vld[3:0]              - per-lane branch flags, lane 0 oldest
//   brch_indx0..3              - ROB index per lane
//   curr_pos                   - free-list pointer at start of group
//   pr_need_inst[3:0]          - per-lane physical register consumption
//   cmt_brch, cmt_brch_indx    - branch commit
//   mis_pred, brch_mis_indx    - branch mispredict
//   stall                      - decode group not accepted
//   flush, flush_pos, flush_indx - one-cycle flush with checkpoint data
//   free_cnt                   - registered count of free slots
// Optional (macro BRCH_CKPT_STATS_EN):
//   mis_cnt   - saturating count of accepted mispredicts
//   stall_cnt - saturating count of stalled cycles with branches present
// -----------------------------------------------------------------------------
module brch_ckpt_ctrl
  import brch_pkg::*;
#(
  parameter int NUM_CKPT  = 4,
  parameter int RECOV_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       brch_vld,
  input  logic [ROB_W-1:0] brch_indx0,
  input  logic [ROB_W-1:0] brch_indx1,
  input  logic [ROB_W-1:0] brch_indx2,
  input  logic [ROB_W-1:0] brch_indx3,
  input  logic [POS_W-1:0] curr_pos,
  input  logic [3:0]       pr_need_inst,
  input  logic             cmt_brch,
  input  logic [ROB_W-1:0] cmt_brch_indx,
  input  logic             mis_pred,
  input  logic [ROB_W-1:0] brch_mis_indx,
  output logic             stall,
  output logic             flush,
  output logic [POS_W-1:0] flush_pos,
  output logic [ROB_W-1:0] flush_indx,
  output logic [3:0]       free_cnt
`ifdef BRCH_CKPT_STATS_EN
  ,
  output logic [15:0]      mis_cnt,
  output logic [15:0]      stall_cnt
`endif
);

  slot_t               slot_q [NUM_CKPT];
  slot_t               slot_d [NUM_CKPT];
  logic [NUM_CKPT-1:0] vld_q;
  logic [NUM_CKPT-1:0] cmt_hit, mis_hit, mis_sel, younger;
  logic [NUM_CKPT-1:0] free_mask, alloc_mask;
  logic [ROB_W-1:0]    lane_indx [NUM_LANES];
  logic [POS_W-1:0]    lane_pos  [NUM_LANES];
  logic [2:0]          brch_num;
  logic                mis_take, accept;
  logic [POS_W-1:0]    sel_pos;
  logic [ROB_W-1:0]    sel_indx;
  logic [3:0]          free_cnt_q, free_cnt_d;

  state_e              state_q, state_d;
  logic                flush_q, flush_d;
  logic [POS_W-1:0]    flush_pos_q, flush_pos_d;
  logic [ROB_W-1:0]    flush_indx_q, flush_indx_d;
  logic [2:0]          recov_cnt_q, recov_cnt_d;

  // The last lane's register use only affects the next group's pointer.
  logic                unused_pr;
  assign unused_pr = pr_need_inst[3];

  assign lane_indx[0] = brch_indx0;
  assign lane_indx[1] = brch_indx1;
  assign lane_indx[2] = brch_indx2;
  assign lane_indx[3] = brch_indx3;

  // Lane position = curr_pos + registers consumed by older lanes (6-bit wrap).
  assign lane_pos[0] = curr_pos;
  for (genvar gi = 1; gi < NUM_LANES; gi++) begin : g_lane_pos
    assign lane_pos[gi] = lane_pos[gi-1] + {{(POS_W-1){1'b0}}, pr_need_inst[gi-1]};
  end

  for (genvar gi = 0; gi < NUM_CKPT; gi++) begin : g_hit
    assign vld_q[gi]   = slot_q[gi].vld;
    assign cmt_hit[gi] = cmt_brch && slot_q[gi].vld && (slot_q[gi].rob_indx == cmt_brch_indx);
    assign mis_hit[gi] = mis_pred && slot_q[gi].vld && (slot_q[gi].rob_indx == brch_mis_indx);
  end

  assign brch_num = 3'(brch_vld[0]) + 3'(brch_vld[1]) + 3'(brch_vld[2]) + 3'(brch_vld[3]);
  assign mis_take = (state_q == ST_IDLE) && (|mis_hit);
  assign stall    = (state_q != ST_IDLE) || mis_pred || ({1'b0, brch_num} > free_cnt_q);
  assign accept   = !stall;

  // Lowest matching slot wins in case of duplicate ROB indices.
  always_comb begin
    logic found;
    found    = 1'b0;
    mis_sel  = '0;
    sel_pos  = '0;
    sel_indx = '0;
    for (int s = 0; s < NUM_CKPT; s++) begin
      if (mis_hit[s] && !found) begin
        found      = 1'b1;
        mis_sel[s] = 1'b1;
        sel_pos    = slot_q[s].pos;
        sel_indx   = slot_q[s].rob_indx;
      end
    end
  end

  assign free_mask = cmt_hit | (mis_take ? (mis_sel | younger) : '0);

  // Slot update: retire freed slots, then hand the free slots (as seen at the
  // start of the cycle) to branch lanes in ascending order.
  always_comb begin
    logic found;
    found      = 1'b0;
    alloc_mask = '0;
    for (int s = 0; s < NUM_CKPT; s++) begin
      slot_d[s] = slot_q[s];
      if (free_mask[s]) begin
        slot_d[s].vld = 1'b0;
      end
    end
    if (accept) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        found = 1'b0;
        for (int s = 0; s < NUM_CKPT; s++) begin
          if (brch_vld[k] && !found && !vld_q[s] && !alloc_mask[s]) begin
            found         = 1'b1;
            alloc_mask[s] = 1'b1;
            slot_d[s]     = {1'b1, lane_indx[k], lane_pos[k]};
          end
        end
      end
    end
  end

  always_comb begin
    free_cnt_d = '0;
    for (int s = 0; s < NUM_CKPT; s++) begin
      if (!slot_d[s].vld) begin
        free_cnt_d = free_cnt_d + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_CKPT; s++) begin
        slot_q[s] <= '0;
      end
      free_cnt_q <= 4'(NUM_CKPT);
    end else begin
      for (int s = 0; s < NUM_CKPT; s++) begin
        slot_q[s] <= slot_d[s];
      end
      free_cnt_q <= free_cnt_d;
    end
  end

  brch_age_matrix #(
    .N (NUM_CKPT)
  ) u_age (
    .clk        (clk),
    .rst_n      (rst_n),
    .vld        (vld_q),
    .alloc_mask (alloc_mask),
    .free_mask  (free_mask),
    .sel        (mis_sel),
    .younger    (younger)
  );

  // Recovery FSM next-state and registered outputs.
  always_comb begin
    state_d      = state_q;
    flush_d      = 1'b0;
    flush_pos_d  = flush_pos_q;
    flush_indx_d = flush_indx_q;
    recov_cnt_d  = recov_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (mis_take) begin
          state_d      = ST_FLUSH;
          flush_d      = 1'b1;
          flush_pos_d  = sel_pos;
          flush_indx_d = sel_indx;
        end
      end
      ST_FLUSH: begin
        state_d     = ST_RECOVER;
        recov_cnt_d = 3'(RECOV_CYC - 1);
      end
      ST_RECOVER: begin
        if (recov_cnt_q == 3'd0) begin
          state_d = ST_IDLE;
        end else begin
          recov_cnt_d = recov_cnt_q - 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      flush_q      <= 1'b0;
      flush_pos_q  <= '0;
      flush_indx_q <= '0;
      recov_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      flush_q      <= flush_d;
      flush_pos_q  <= flush_pos_d;
      flush_indx_q <= flush_indx_d;
      recov_cnt_q  <= recov_cnt_d;
    end
  end

  assign flush      = flush_q;
  assign flush_pos  = flush_pos_q;
  assign flush_indx = flush_indx_q;
  assign free_cnt   = free_cnt_q;

`ifdef BRCH_CKPT_STATS_EN
  logic [15:0] mis_cnt_q, mis_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    mis_cnt_d   = mis_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (mis_take && (mis_cnt_q != 16'hFFFF)) begin
      mis_cnt_d = mis_cnt_q + 16'd1;
    end
    if (stall && (brch_vld != 4'd0) && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      mis_cnt_q   <= mis_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mis_cnt   = mis_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_brch_ckpt_ctrl.sv
// -----------------------------------------------------------------------------
// tb_brch_ckpt_ctrl
// Directed bench for brch_ckpt_ctrl (NUM_CKPT=4, RECOV_CYC=2). Inputs change
// 1ns after the rising edge; outputs are sampled 2ns after the edge.
// -----------------------------------------------------------------------------
module tb_brch_ckpt_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] brch_vld;
  logic [5:0] brch_indx0, brch_indx1, brch_indx2, brch_indx3;
  logic [5:0] curr_pos;
  logic [3:0] pr_need_inst;
  logic       cmt_brch;
  logic [5:0] cmt_brch_indx;
  logic       mis_pred;
  logic [5:0] brch_mis_indx;
  logic       stall, flush;
  logic [5:0] flush_pos, flush_indx;
  logic [3:0] free_cnt;
`ifdef BRCH_CKPT_STATS_EN
  logic [15:0] mis_cnt, stall_cnt;
`endif

  int vec  = 0;
  int errs = 0;

  always #5 clk = ~clk;

  brch_ckpt_ctrl #(
    .NUM_CKPT  (4),
    .RECOV_CYC (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .brch_vld      (brch_vld),
    .brch_indx0    (brch_indx0),
    .brch_indx1    (brch_indx1),
    .brch_indx2    (brch_indx2),
    .brch_indx3    (brch_indx3),
    .curr_pos      (curr_pos),
    .pr_need_inst  (pr_need_inst),
    .cmt_brch      (cmt_brch),
    .cmt_brch_indx (cmt_brch_indx),
    .mis_pred      (mis_pred),
    .brch_mis_indx (brch_mis_indx),
    .stall         (stall),
    .flush         (flush),
    .flush_pos     (flush_pos),
    .flush_indx    (flush_indx),
    .free_cnt      (free_cnt)
`ifdef BRCH_CKPT_STATS_EN
    ,
    .mis_cnt       (mis_cnt),
    .stall_cnt     (stall_cnt)
`endif
  );

  task automatic clr_in();
    brch_vld      = 4'd0;
    brch_indx0    = 6'd0;
    brch_indx1    = 6'd0;
    brch_indx2    = 6'd0;
    brch_indx3    = 6'd0;
    curr_pos      = 6'd0;
    pr_need_inst  = 4'd0;
    cmt_brch      = 1'b0;
    cmt_brch_indx = 6'd0;
    mis_pred      = 1'b0;
    brch_mis_indx = 6'd0;
  endtask

  // Advance one edge; inputs are cleared just after it, sampling follows 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
    clr_in();
    #1;
  endtask

  task automatic test_reset();
    clr_in();
    rst_n = 1'b0;
    #12;
    vec++; if (flush !== 1'b0) begin errs++; $display("FAIL rst_flush got=%0b exp=0", flush); end
    vec++; if (flush_pos !== 6'd0) begin errs++; $display("FAIL rst_flush_pos got=%0d exp=0", flush_pos); end
    vec++; if (flush_indx !== 6'd0) begin errs++; $display("FAIL rst_flush_indx got=%0d exp=0", flush_indx); end
    vec++; if (free_cnt !== 4'd4) begin errs++; $display("FAIL rst_free_cnt got=%0d exp=4", free_cnt); end
    vec++; if (stall !== 1'b0) begin errs++; $display("FAIL rst_stall got=%0b exp=0", stall); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
  endtask

  // Lanes 0 and 2: positions 62 and 62+2 = 0 (wrap).
  task automatic test_alloc_wrap();
    brch_vld = 4'b0101; brch_indx0 = 6'd10; brch_indx2 = 6'd11;
    curr_pos = 6'd62; pr_need_inst = 4'b1111;
    #1;
    vec++; if (stall !== 1'b0) begin errs++; $display("FAIL wrap_stall got=%0b exp=0", stall); end
    tick();
    vec++; if (free_cnt !== 4'd2) begin errs++; $display("FAIL wrap_free_cnt got=%0d exp=2", free_cnt); end
  endtask

  task automatic test_stall_full();
    brch_vld = 4'b0111; brch_indx0 = 6'd50; brch_indx1 = 6'd51; brch_indx2 = 6'd52;
    #1;
    vec++; if (stall !== 1'b1) begin errs++; $display("FAIL full_stall got=%0b exp=1", stall); end
    tick();
    vec++; if (free_cnt !== 4'd2) begin errs++; $display("FAIL full_free_cnt got=%0d exp=2", free_cnt); end
  endtask

  // Mispredict the lane-2 branch (ROB 11, pos 0): only its slot is younger-or-equal.
  task automatic test_mispredict_wrap();
    mis_pred = 1'b1; brch_mis_indx = 6'd11;
    #1;
    vec++; if (stall !== 1'b1) begin errs++; $display("FAIL mw_detect_stall got=%0b exp=1", stall); end
    tick();
    vec++; if (flush !== 1'b1) begin errs++; $display("FAIL mw_flush got=%0b exp=1", flush); end
    vec++; if (flush_indx !== 6'd11) begin errs++; $display("FAIL mw_flush_indx got=%0d exp=11", flush_indx); end
    vec++; if (flush_pos !== 6'd0) begin errs++; $display("FAIL mw_flush_pos got=%0d exp=0", flush_pos); end
    vec++; if (free_cnt !== 4'd3) begin errs++; $display("FAIL mw_free_cnt got=%0d exp=3", free_cnt); end
    tick(); tick(); tick();
    vec++; if (stall !== 1'b0) begin errs++; $display("FAIL mw_idle_stall got=%0b exp=0", stall); end
    vec++; if (flush_indx !== 6'd11) begin errs++; $display("FAIL mw_hold_indx got=%0d exp=11", flush_indx); end
  endtask

  task automatic test_commit();
    cmt_brch = 1'b1; cmt_brch_indx = 6'd33;
    tick();
    vec++; if (free_cnt !== 4'd3) begin errs++; $display("FAIL cmt_nomatch got=%0d exp=3", free_cnt); end
    cmt_brch = 1'b1; cmt_brch_indx = 6'd10;
    tick();
    vec++; if (free_cnt !== 4'd4) begin errs++; $display("FAIL cmt_match got=%0d exp=4", free_cnt); end
  endtask

  // ROB 5 (pos 20), 9 (pos 31), 12 (pos 43) in three groups; mispredict 9.
  task automatic test_flush_seq();
    brch_vld = 4'b0001; brch_indx0 = 6'd5; curr_pos = 6'd20;
    tick();
    brch_vld = 4'b0010; brch_indx1 = 6'd9; curr_pos = 6'd30; pr_need_inst = 4'b0001;
    tick();
    brch_vld = 4'b1000; brch_indx3 = 6'd12; curr_pos = 6'd40; pr_need_inst = 4'b0111;
    tick();
    vec++; if (free_cnt !== 4'd1) begin errs++; $display("FAIL fs_alloc_cnt got=%0d exp=1", free_cnt); end
    mis_pred = 1'b1; brch_mis_indx = 6'd9;
    tick();
    vec++; if (flush !== 1'b1) begin errs++; $display("FAIL fs_flush got=%0b exp=1", flush); end
    vec++; if (flush_indx !== 6'd9) begin errs++; $display("FAIL fs_flush_indx got=%0d exp=9", flush_indx); end
    vec++; if (flush_pos !== 6'd31) begin errs++; $display("FAIL fs_flush_pos got=%0d exp=31", flush_pos); end
    vec++; if (free_cnt !== 4'd3) begin errs++; $display("FAIL fs_free_cnt got=%0d exp=3", free_cnt); end
    vec++; if (stall !== 1'b1) begin errs++; $display("FAIL fs_stall_flush got=%0b exp=1", stall); end
    // Mispredict on ROB 5 while in FLUSH must be ignored.
    mis_pred = 1'b1; brch_mis_indx = 6'd5;
    tick();
    vec++; if (flush !== 1'b0) begin errs++; $display("FAIL fs_single_pulse got=%0b exp=0", flush); end
    vec++; if (stall !== 1'b1) begin errs++; $display("FAIL fs_stall_rec1 got=%0b exp=1", stall); end
    tick();
    vec++; if (stall !== 1'b1) begin errs++; $display("FAIL fs_stall_rec2 got=%0b exp=1", stall); end
    tick();
    vec++; if (stall !== 1'b0) begin errs++; $display("FAIL fs_stall_idle got=%0b exp=0", stall); end
    vec++; if (free_cnt !== 4'd3) begin errs++; $display("FAIL fs_ignored_mis got=%0d exp=3", free_cnt); end
    vec++; if (flush_indx !== 6'd9) begin errs++; $display("FAIL fs_hold_indx got=%0d exp=9", flush_indx); end
  endtask

  task automatic test_commit_mis_same();
    cmt_brch = 1'b1; cmt_brch_indx = 6'd5; mis_pred = 1'b1; brch_mis_indx = 6'd5;
    tick();
    vec++; if (flush !== 1'b1) begin errs++; $display("FAIL cms_flush got=%0b exp=1", flush); end
    vec++; if (flush_indx !== 6'd5) begin errs++; $display("FAIL cms_flush_indx got=%0d exp=5", flush_indx); end
    vec++; if (flush_pos !== 6'd20) begin errs++; $display("FAIL cms_flush_pos got=%0d exp=20", flush_pos); end
    vec++; if (free_cnt !== 4'd4) begin errs++; $display("FAIL cms_free_cnt got=%0d exp=4", free_cnt); end
    tick(); tick(); tick();
  endtask

  // Commit older ROB 7 while mispredicting younger ROB 8 (pos 4).
  task automatic test_commit_older();
    brch_vld = 4'b0011; brch_indx0 = 6'd7; brch_indx1 = 6'd8; curr_pos = 6'd3; pr_need_inst = 4'b0001;
    tick();
    vec++; if (free_cnt !== 4'd2) begin errs++; $display("FAIL co_alloc_cnt got=%0d exp=2", free_cnt); end
    cmt_brch = 1'b1; cmt_brch_indx = 6'd7; mis_pred = 1'b1; brch_mis_indx = 6'd8;
    tick();
    vec++; if (flush_indx !== 6'd8) begin errs++; $display("FAIL co_flush_indx got=%0d exp=8", flush_indx); end
    vec++; if (flush_pos !== 6'd4) begin errs++; $display("FAIL co_flush_pos got=%0d exp=4", flush_pos); end
    vec++; if (free_cnt !== 4'd4) begin errs++; $display("FAIL co_free_cnt got=%0d exp=4", free_cnt); end
    tick(); tick(); tick();
  endtask

  task automatic test_unmatched();
    mis_pred = 1'b1; brch_mis_indx = 6'd40; brch_vld = 4'b0001; brch_indx0 = 6'd1;
    #1;
    vec++; if (stall !== 1'b1) begin errs++; $display("FAIL um_stall got=%0b exp=1", stall); end
    tick();
    vec++; if (flush !== 1'b0) begin errs++; $display("FAIL um_flush got=%0b exp=0", flush); end
    vec++; if (stall !== 1'b0) begin errs++; $display("FAIL um_stall_after got=%0b exp=0", stall); end
    vec++; if (free_cnt !== 4'd4) begin errs++; $display("FAIL um_no_alloc got=%0d exp=4", free_cnt); end
    vec++; if (flush_indx !== 6'd8) begin errs++; $display("FAIL um_hold_indx got=%0d exp=8", flush_indx); end
  endtask

  // Fill all slots, reuse a committed slot, then flush from the second-oldest.
  task automatic test_back_to_back();
    brch_vld = 4'b1111; brch_indx0 = 6'd20; brch_indx1 = 6'd21; brch_indx2 = 6'd22; brch_indx3 = 6'd23;
    curr_pos = 6'd50; pr_need_inst = 4'b1111;
    tick();
    vec++; if (free_cnt !== 4'd0) begin errs++; $display("FAIL bb_full_cnt got=%0d exp=0", free_cnt); end
    brch_vld = 4'b0001; brch_indx0 = 6'd24; cmt_brch = 1'b1; cmt_brch_indx = 6'd20;
    #1;
    vec++; if (stall !== 1'b1) begin errs++; $display("FAIL bb_no_reuse got=%0b exp=1", stall); end
    tick();
    vec++; if (free_cnt !== 4'd1) begin errs++; $display("FAIL bb_freed_cnt got=%0d exp=1", free_cnt); end
    brch_vld = 4'b0001; brch_indx0 = 6'd24; curr_pos = 6'd9;
    #1;
    vec++; if (stall !== 1'b0) begin errs++; $display("FAIL bb_reuse_stall got=%0b exp=0", stall); end
    tick();
    vec++; if (free_cnt !== 4'd0) begin errs++; $display("FAIL bb_reuse_cnt got=%0d exp=0", free_cnt); end
    mis_pred = 1'b1; brch_mis_indx = 6'd21;
    tick();
    vec++; if (flush_indx !== 6'd21) begin errs++; $display("FAIL bb_flush_indx got=%0d exp=21", flush_indx); end
    vec++; if (flush_pos !== 6'd51) begin errs++; $display("FAIL bb_flush_pos got=%0d exp=51", flush_pos); end
    vec++; if (free_cnt !== 4'd4) begin errs++; $display("FAIL bb_flush_all got=%0d exp=4", free_cnt); end
    tick(); tick(); tick();
  endtask

  task automatic test_reset_mid();
`ifdef BRCH_CKPT_STATS_EN
    vec++; if (mis_cnt !== 16'd5) begin errs++; $display("FAIL st_mis_cnt got=%0d exp=5", mis_cnt); end
`endif
    // Reset during FLUSH.
    brch_vld = 4'b0001; brch_indx0 = 6'd30;
    tick();
    mis_pred = 1'b1; brch_mis_indx = 6'd30;
    tick();
    vec++; if (flush !== 1'b1) begin errs++; $display("FAIL rm_flush_pre got=%0b exp=1", flush); end
    rst_n = 1'b0;
    #1;
    vec++; if (flush !== 1'b0) begin errs++; $display("FAIL rm_flush_abort got=%0b exp=0", flush); end
    tick();
    rst_n = 1'b1;
    // Reset during RECOVER.
    brch_vld = 4'b0001; brch_indx0 = 6'd31;
    tick();
    mis_pred = 1'b1; brch_mis_indx = 6'd31;
    tick();
    tick();
    vec++; if (stall !== 1'b1) begin errs++; $display("FAIL rr_stall_pre got=%0b exp=1", stall); end
    rst_n = 1'b0;
    #1;
    vec++; if (stall !== 1'b0) begin errs++; $display("FAIL rr_stall got=%0b exp=0", stall); end
    vec++; if (free_cnt !== 4'd4) begin errs++; $display("FAIL rr_free_cnt got=%0d exp=4", free_cnt); end
    vec++; if (flush !== 1'b0) begin errs++; $display("FAIL rr_flush got=%0b exp=0", flush); end
`ifdef BRCH_CKPT_STATS_EN
    vec++; if (mis_cnt !== 16'd0) begin errs++; $display("FAIL rr_mis_cnt got=%0d exp=0", mis_cnt); end
`endif
    tick();
    rst_n = 1'b1;
    tick();
    vec++; if (flush !== 1'b0) begin errs++; $display("FAIL rr_no_residual got=%0b exp=0", flush); end
    vec++; if (stall !== 1'b0) begin errs++; $display("FAIL rr_idle got=%0b exp=0", stall); end
  endtask

  initial begin
    test_reset();
    test_alloc_wrap();
    test_stall_full();
    test_mispredict_wrap();
    test_commit();
    test_flush_seq();
    test_commit_mis_same();
    test_commit_older();
    test_unmatched();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/brch_ckpt_ctrl.md
BRCH_CKPT_CTRL -- requirements
Module: brch_ckpt_ctrl

Interface
REQ-001 SHALL have parameter NUM_CKPT, default 4, number of branch checkpoint slots (2..8).
REQ-002 SHALL have parameter RECOV_CYC, default 2, recovery cycles after a flush (1..7).
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk  in  1  clock; rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have brch_vld  in  4  per-lane "decoded instruction is a branch" flags, lane 0 oldest.
REQ-005 SHALL have brch_indx0..brch_indx3  in  6 each  ROB index per lane.
REQ-006 SHALL have curr_pos  in  6  free-list pointer at the start of the group.
REQ-007 SHALL have pr_need_inst  in  4  per-lane "lane consumes a physical register" flags.
REQ-008 SHALL have cmt_brch  in  1  and cmt_brch_indx  in  6: branch committed, with its ROB index.
REQ-009 SHALL have mis_pred  in  1  and brch_mis_indx  in  6: branch mispredicted, with its ROB index.
REQ-010 SHALL have stall  out  1  (decode group not accepted), flush  out  1, flush_pos  out  6, flush_indx  out  6, free_cnt  out  4.

Function
REQ-011 Each slot SHALL hold {vld, rob_indx[5:0], pos[5:0]} plus an age relation to every other slot.
REQ-012 Lane k position SHALL be curr_pos + sum of pr_need_inst[j] for j<k, computed modulo 64 (6-bit wrap).
REQ-013 Allocation SHALL be all-or-nothing: if popcount(brch_vld) > free_cnt, then stall=1 and no slot is written.
REQ-014 On acceptance, branch lanes SHALL take free slots in ascending slot order, lowest branch lane first; slots become valid the next cycle, and each new slot is marked younger than all valid slots and than slots from lower lanes.
REQ-015 free_cnt SHALL be the registered count of invalid slots; slots freed this cycle SHALL NOT be reused until the next cycle.
REQ-016 cmt_brch matching a valid slot's rob_indx SHALL clear that slot next cycle; a commit with no match is ignored.
REQ-017 The FSM SHALL have the states IDLE, FLUSH and RECOVER.
REQ-018 In IDLE, mis_pred matching a valid slot S SHALL transition to FLUSH and invalidate S and every slot younger than S next cycle.
REQ-019 In IDLE, mis_pred with no matching slot SHALL be ignored, with no transition.
REQ-020 In FLUSH, flush=1 for exactly one cycle, with flush_pos=S.pos and flush_indx=S.rob_indx registered at detection; the FSM then goes to RECOVER.
REQ-021 RECOVER SHALL last RECOV_CYC cycles, then return to IDLE.
REQ-022 stall SHALL be 1 whenever the state is not IDLE, or mis_pred=1 in IDLE; no allocation occurs in those cycles.
REQ-023 mis_pred in FLUSH or RECOVER SHALL be ignored.
REQ-024 When commit and mispredict hit the same slot in the same cycle, the mispredict SHALL take precedence.
REQ-025 A commit of an older slot in the same cycle as a mispredict SHALL still clear that older slot.
REQ-026 flush_pos and flush_indx SHALL hold their last value outside FLUSH.

Reset
REQ-027 rst_n low SHALL asynchronously force the FSM to IDLE, all slots invalid, and the age matrix to zero.
REQ-028 Reset values SHALL be flush=0, flush_pos=0, flush_indx=0, free_cnt=NUM_CKPT and stall=0.
REQ-029 Reset asserted mid-FLUSH or mid-RECOVER SHALL abort the sequence, with no residual flush pulse.

Configuration
REQ-030 With macro BRCH_CKPT_STATS_EN defined, the block SHALL add mis_cnt  out  16 (accepted mispredicts) and stall_cnt  out  16 (cycles with stall=1 and brch_vld!=0).
REQ-031 Both counters SHALL saturate at 16'hFFFF and reset to 0.
REQ-032 Without BRCH_CKPT_STATS_EN, the ports, counters and logic SHALL be absent, with no other behaviour change.

Structure
REQ-033 Package brch_pkg SHALL hold NUM_LANES=4, the ROB index width (6), the FSM state enum and the slot entry struct.
REQ-034 The age relation SHALL be a sub-module brch_age_matrix, an NUM_CKPT x NUM_CKPT older-than matrix with set-on-alloc, clear-on-free and a younger-than-S vector output.

Verification
REQ-035 Reset, then brch_vld=4'b0101, curr_pos=62, pr_need_inst=4'b1111 -> slots 0,1 get pos 62 and 0 (wrap), free_cnt=2 next cycle.
REQ-036 With free_cnt=2, brch_vld=4'b0111 -> stall=1, no slot written, free_cnt stays 2.
REQ-037 Branches at ROB 5, 9, 12 allocated in order; mis_pred with indx 9 -> one flush pulse with flush_indx=9 and its pos; slots for 9 and 12 freed; stall=1 for 1+RECOV_CYC cycles; free_cnt=NUM_CKPT-1.
REQ-038 cmt_brch=1 and mis_pred=1 with the same indx 5 -> flush asserted, slot freed once, free_cnt correct.
REQ-039 mis_pred with an unmatched indx 40 -> no flush, stall only in that cycle.
REQ-040 rst_n pulsed during RECOVER -> IDLE, free_cnt=NUM_CKPT, flush=0; with BRCH_CKPT_STATS_EN, mis_cnt=0.
